// File: rtl/logic_gates_selftest_ctrl.sv
// Clocked self-test sequencer for the 2-input gate unit: walks a/b through 00..11 and checks all seven outputs.
// Optional failure log (fail_valid/fail_vec/fail_mask) is enabled by defining LOGIC_GATES_SELFTEST_ERRLOG_EN.
module logic_gates_selftest_ctrl #(
    parameter int SETTLE_CYCLES = 2,
    parameter int ERR_W         = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             a,
    output logic             b,
    input  logic             yand,
    input  logic             ynand,
    input  logic             yor,
    input  logic             ynor,
    input  logic             ynot,
    input  logic             yxor,
    input  logic             yxnor,
`ifdef LOGIC_GATES_SELFTEST_ERRLOG_EN
    output logic             fail_valid,
    output logic [1:0]       fail_vec,
    output logic [6:0]       fail_mask,
`endif
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count
);

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CHECK, S_DONE} state_t;

    localparam logic [7:0]       SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [ERR_W-1:0] ERR_MAX     = '1;

    state_t           r_state, w_state_nxt;
    logic [1:0]       r_vec, w_vec_nxt;
    logic [7:0]       r_cnt, w_cnt_nxt;
    logic             r_a, w_a_nxt;
    logic             r_b, w_b_nxt;
    logic [ERR_W-1:0] r_err, w_err_nxt, w_err_inc;
    logic             r_pass, w_pass_nxt;
    logic [6:0]       w_act, w_exp, w_mm;
    logic             w_mismatch;

`ifdef LOGIC_GATES_SELFTEST_ERRLOG_EN
    logic             r_fail_valid, w_fail_valid_nxt;
    logic [1:0]       r_fail_vec, w_fail_vec_nxt;
    logic [6:0]       r_fail_mask, w_fail_mask_nxt;
`endif

    assign w_act = {yand, ynand, yor, ynor, ynot, yxor, yxnor};
    assign w_exp = {r_a & r_b, ~(r_a & r_b), r_a | r_b, ~(r_a | r_b), ~r_a, r_a ^ r_b, ~(r_a ^ r_b)};
    assign w_mm  = w_act ^ w_exp;

    // Written so an unknown compare result in simulation falls through as a mismatch.
    always_comb begin
        w_mismatch = 1'b1;
        if (w_mm == 7'b0) w_mismatch = 1'b0;
    end

    assign w_err_inc = (w_mismatch && (r_err != ERR_MAX)) ? r_err + 1'b1 : r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_vec   <= 2'd0;
            r_cnt   <= 8'd0;
            r_a     <= 1'b0;
            r_b     <= 1'b0;
            r_err   <= '0;
            r_pass  <= 1'b0;
`ifdef LOGIC_GATES_SELFTEST_ERRLOG_EN
            r_fail_valid <= 1'b0;
            r_fail_vec   <= 2'd0;
            r_fail_mask  <= 7'd0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_vec   <= w_vec_nxt;
            r_cnt   <= w_cnt_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_err   <= w_err_nxt;
            r_pass  <= w_pass_nxt;
`ifdef LOGIC_GATES_SELFTEST_ERRLOG_EN
            r_fail_valid <= w_fail_valid_nxt;
            r_fail_vec   <= w_fail_vec_nxt;
            r_fail_mask  <= w_fail_mask_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_vec_nxt   = r_vec;
        w_cnt_nxt   = r_cnt;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_err_nxt   = r_err;
        w_pass_nxt  = r_pass;
`ifdef LOGIC_GATES_SELFTEST_ERRLOG_EN
        w_fail_valid_nxt = r_fail_valid;
        w_fail_vec_nxt   = r_fail_vec;
        w_fail_mask_nxt  = r_fail_mask;
`endif
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_nxt = S_SETTLE;
                    w_vec_nxt   = 2'd0;
                    w_cnt_nxt   = 8'd0;
                    w_a_nxt     = 1'b0;
                    w_b_nxt     = 1'b0;
                    w_err_nxt   = '0;
                    w_pass_nxt  = 1'b0;
`ifdef LOGIC_GATES_SELFTEST_ERRLOG_EN
                    w_fail_valid_nxt = 1'b0;
                    w_fail_vec_nxt   = 2'd0;
                    w_fail_mask_nxt  = 7'd0;
`endif
                end
            end
            S_SETTLE: begin
                w_cnt_nxt = r_cnt + 8'd1;
                if (r_cnt == SETTLE_LAST) w_state_nxt = S_CHECK;
            end
            S_CHECK: begin
                w_err_nxt = w_err_inc;
`ifdef LOGIC_GATES_SELFTEST_ERRLOG_EN
                // Only the first failing vector of a run is kept.
                if (w_mismatch && !r_fail_valid) begin
                    w_fail_valid_nxt = 1'b1;
                    w_fail_vec_nxt   = r_vec;
                    w_fail_mask_nxt  = w_mm;
                end
`endif
                if (r_vec == 2'd3) begin
                    w_state_nxt = S_DONE;
                    w_pass_nxt  = (w_err_inc == '0);
                end else begin
                    w_state_nxt          = S_SETTLE;
                    w_vec_nxt            = r_vec + 2'd1;
                    {w_a_nxt, w_b_nxt}   = r_vec + 2'd1;
                    w_cnt_nxt            = 8'd0;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign a         = r_a;
    assign b         = r_b;
    assign busy      = (r_state == S_SETTLE) || (r_state == S_CHECK);
    assign done      = (r_state == S_DONE);
    assign pass      = r_pass;
    assign err_count = r_err;
`ifdef LOGIC_GATES_SELFTEST_ERRLOG_EN
    assign fail_valid = r_fail_valid;
    assign fail_vec   = r_fail_vec;
    assign fail_mask  = r_fail_mask;
`endif

endmodule

// File: tb/tb_logic_gates_selftest_ctrl.sv
// Scoreboard bench for logic_gates_selftest_ctrl: three instances cover default timing, ERR_W=1 saturation
// and SETTLE_CYCLES=1 back-to-back runs, each fed by a behavioural gate unit with injectable faults.
module tb_logic_gates_selftest_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Behavioural gate unit; mode 0 good, 1 yxor stuck at 0, 2 every output inverted.
    function automatic logic [6:0] gates(input logic [1:0] ab, input int mode);
        logic [6:0] g;
        case (ab)
            2'b00:   g = 7'b0101101;
            2'b01:   g = 7'b0110110;
            2'b10:   g = 7'b0110010;
            default: g = 7'b1010001;
        endcase
        if (mode == 1) g[1] = 1'b0;
        if (mode == 2) g = ~g;
        return g;
    endfunction

    typedef struct packed {
        logic       pass;
        logic [2:0] err;
        logic       fv;
        logic [1:0] fvec;
        logic [6:0] fmask;
    } res_t;

    typedef struct packed {
        logic busy;
        logic done;
        logic a;
        logic b;
    } cyc_t;

    res_t q0[$], q1[$], q2[$];
    cyc_t qc[$];

    function automatic res_t model(input int mode, input int errmax);
        res_t r;
        logic [6:0] mm;
        int e;
        r = '0;
        e = 0;
        for (int v = 0; v < 4; v++) begin
            mm = gates(2'(v), mode) ^ gates(2'(v), 0);
            if (mm != 7'd0) begin
                if (e < errmax) e++;
                if (!r.fv) begin
                    r.fv    = 1'b1;
                    r.fvec  = 2'(v);
                    r.fmask = mm;
                end
            end
        end
        r.err  = 3'(e);
        r.pass = (e == 0);
        return r;
    endfunction

    // Instance 0: defaults
    logic st0, a0, b0, busy0, done0, pass0;
    logic [2:0] err0;
    logic [6:0] y0;
    int mode0 = 0;
    always_comb y0 = gates({a0, b0}, mode0);
    // Instance 1: ERR_W=1
    logic st1, a1, b1, busy1, done1, pass1;
    logic [0:0] err1;
    logic [6:0] y1;
    int mode1 = 2;
    always_comb y1 = gates({a1, b1}, mode1);
    // Instance 2: SETTLE_CYCLES=1
    logic st2, a2, b2, busy2, done2, pass2;
    logic [2:0] err2;
    logic [6:0] y2;
    int mode2 = 2;
    always_comb y2 = gates({a2, b2}, mode2);

`ifdef LOGIC_GATES_SELFTEST_ERRLOG_EN
    logic fv0, fv1, fv2;
    logic [1:0] fvec0, fvec1, fvec2;
    logic [6:0] fm0, fm1, fm2;
`endif

    logic_gates_selftest_ctrl #(.SETTLE_CYCLES(2), .ERR_W(3)) u_dut0 (
        .clk(clk), .rst(rst), .start(st0), .a(a0), .b(b0),
        .yand(y0[6]), .ynand(y0[5]), .yor(y0[4]), .ynor(y0[3]), .ynot(y0[2]), .yxor(y0[1]), .yxnor(y0[0]),
`ifdef LOGIC_GATES_SELFTEST_ERRLOG_EN
        .fail_valid(fv0), .fail_vec(fvec0), .fail_mask(fm0),
`endif
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0)
    );

    logic_gates_selftest_ctrl #(.SETTLE_CYCLES(2), .ERR_W(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(st1), .a(a1), .b(b1),
        .yand(y1[6]), .ynand(y1[5]), .yor(y1[4]), .ynor(y1[3]), .ynot(y1[2]), .yxor(y1[1]), .yxnor(y1[0]),
`ifdef LOGIC_GATES_SELFTEST_ERRLOG_EN
        .fail_valid(fv1), .fail_vec(fvec1), .fail_mask(fm1),
`endif
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1)
    );

    logic_gates_selftest_ctrl #(.SETTLE_CYCLES(1), .ERR_W(3)) u_dut2 (
        .clk(clk), .rst(rst), .start(st2), .a(a2), .b(b2),
        .yand(y2[6]), .ynand(y2[5]), .yor(y2[4]), .ynor(y2[3]), .ynot(y2[2]), .yxor(y2[1]), .yxnor(y2[0]),
`ifdef LOGIC_GATES_SELFTEST_ERRLOG_EN
        .fail_valid(fv2), .fail_vec(fvec2), .fail_mask(fm2),
`endif
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err2)
    );

    // One run on instance 0. restart_j re-pulses start mid-run; rst_j asserts rst at that sample.
    task automatic run0(input int mode, input int restart_j, input int rst_j);
        cyc_t c;
        res_t r;
        mode0 = mode;
        for (int j = 0; j <= 12; j++) begin
            c.busy = (j < 12);
            c.done = (j == 12);
            {c.a, c.b} = (j < 12) ? 2'(j / 3) : 2'b11;
            qc.push_back(c);
        end
        q0.push_back(model(mode, 7));
        @(negedge clk) st0 = 1'b1;
        @(negedge clk) st0 = 1'b0;
        for (int j = 0; j <= 12; j++) begin
            if (j > 0) @(negedge clk);
            st0 = (j == restart_j);
            c = qc.pop_front();
            chk($sformatf("d0_busy_j%0d", j), busy0, c.busy);
            chk($sformatf("d0_done_j%0d", j), done0, c.done);
            chk($sformatf("d0_ab_j%0d", j), {a0, b0}, {c.a, c.b});
            if (j == rst_j) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                chk("rst_busy", busy0, 0);
                chk("rst_done", done0, 0);
                chk("rst_ab", {a0, b0}, 0);
                chk("rst_err", err0, 0);
                chk("rst_pass", pass0, 0);
                qc.delete();
                q0.delete();
                return;
            end
            if (j == 12) begin
                r = q0.pop_front();
                chk("d0_pass", pass0, r.pass);
                chk("d0_err", err0, r.err);
`ifdef LOGIC_GATES_SELFTEST_ERRLOG_EN
                chk("d0_fv", fv0, r.fv);
                chk("d0_fvec", fvec0, r.fvec);
                chk("d0_fmask", fm0, r.fmask);
`endif
            end
        end
    endtask

    initial begin
        res_t r;
        int   lows, npulse, tmo;
        logic prev;
        rst = 1'b1; st0 = 1'b0; st1 = 1'b0; st2 = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_busy", busy0, 0);
        chk("reset_done", done0, 0);
        chk("reset_ab", {a0, b0}, 0);
        chk("reset_pass", pass0, 0);
        chk("reset_err", err0, 0);
        rst = 1'b0;
        @(negedge clk);

        run0(0, -1, -1);
        run0(1, -1, -1);
        run0(2, -1, -1);
        run0(0, 5, -1);
        run0(1, -1, 7);
        run0(0, -1, -1);

        // ERR_W=1, every output wrong: count must stick at 1
        q1.push_back(model(2, 1));
        @(negedge clk) st1 = 1'b1;
        @(negedge clk) st1 = 1'b0;
        tmo = 0;
        while (!done1 && tmo < 30) begin
            @(negedge clk);
            tmo++;
        end
        chk("d1_timeout", done1, 1);
        r = q1.pop_front();
        chk("d1_err_sat", err1, r.err[0]);
        chk("d1_pass", pass1, r.pass);
`ifdef LOGIC_GATES_SELFTEST_ERRLOG_EN
        chk("d1_fv", fv1, r.fv);
        chk("d1_fvec", fvec1, r.fvec);
        chk("d1_fmask", fm1, r.fmask);
`endif

        // SETTLE_CYCLES=1 with start held: 8 busy cycles then a 1-cycle done, repeated
        for (int k = 0; k < 5; k++) q2.push_back(model(2, 7));
        @(negedge clk) st2 = 1'b1;
        lows = 0; npulse = 0; prev = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done2) begin
                if (prev) chk("d2_width", 2, 1);
                else begin
                    chk("d2_gap", lows, 8);
                    r = q2.pop_front();
                    chk("d2_err", err2, r.err);
                    chk("d2_pass", pass2, r.pass);
                end
                npulse++;
                lows = 0;
            end else lows++;
            prev = done2;
        end
        st2 = 1'b0;
        chk("d2_pulses", npulse, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
